uart_axil_program_loader: RTL
=============================

Name: uart_axil_program_loader

Overview:
AXI4-lite initiator that fetches a length-prefixed program image from the UART peripheral and writes it into data memory as 64-bit words. It pairs with the UART and memory AXI4-lite responders, acting as their master on a boot/debug path. It drives the UART read channel (rd_mst) and the memory write channel (wr_mst) through the memory controller. `busy` holds the core in reset until the image is loaded.

Parameters:
UART_RX_ADDR, 64'h1000_0000, UART RX register address; rdata[8]=byte valid (read pops), rdata[7:0]=byte
LOAD_BASE, 64'h0000_0000, byte address of first image word (8-byte aligned)
MAX_BYTES, 32'd65536, largest accepted payload length

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a load, ignored unless IDLE/DONE/ERROR
uart_rd  axil_interface_if.rd_mst  DATA_W=64  reads UART_RX_ADDR
mem_wr  axil_interface_if.wr_mst  DATA_W=64  writes image words
busy  out  1  high from accepted start until DONE/ERROR
done  out  1  level, high in DONE
error  out  1  level, high in ERROR
bytes_loaded  out  32  payload bytes committed to memory so far

Behaviour:
- Reset: state=IDLE. busy, done and error are 0. bytes_loaded=0. arvalid, rready, awvalid, wvalid and bready are 0. araddr, awaddr and wdata are 0. wstrb=0.
- Reset mid-transaction drops all valids immediately; no completion is owed.
- States: IDLE, AR, R, PROCESS, AW_W, B, DONE, ERROR.
- start in IDLE/DONE/ERROR: clear counters, the packing buffer, done and error; go to AR; busy=1.
- AR: araddr=UART_RX_ADDR, arvalid=1. Hold araddr and arvalid stable until arready, then go to R.
- R: rready=1 and capture rdata on rvalid.
  - rresp!=0 -> ERROR.
  - rdata[8]=0 -> AR (re-poll, no byte consumed).
  - Otherwise -> PROCESS with the captured byte.
- PROCESS, header phase (first 4 bytes): assemble length N little-endian.
  - After byte 4, N=0 -> DONE.
  - After byte 4, N>MAX_BYTES -> ERROR.
  - Otherwise -> AR.
- PROCESS, payload phase: place the byte at lane (byte_idx mod 8) of a 64-bit buffer and set that lane's strobe bit.
  - Go to AW_W when the lane was 7 or the byte was the Nth.
  - Otherwise -> AR.
- AW_W:
  - awaddr = LOAD_BASE + 8*word_idx.
  - wdata = buffer; unfilled lanes are 0.
  - wstrb = accumulated lanes: 8'hFF for a full word, low-contiguous mask for the final partial word.
  - awvalid and wvalid rise together. Each drops independently on its own handshake; both handshakes may occur in the same cycle.
  - Once both are complete -> B.
- B: bready=1. On bvalid:
  - bresp!=0 -> ERROR.
  - Otherwise: bytes_loaded += bytes in word; word_idx++; clear buffer and strobes.
  - Then go to DONE if bytes_loaded==N, else AR.
- Latency minimum per byte is 3 cycles (AR, R, PROCESS) with arready and rvalid immediate. A word adds at least 2 cycles.
- Widths: byte counters are 32-bit. The address sum wraps at 64 bits with no error.
- start while busy: ignored.
- rvalid/bvalid while not in R/B: ignored; bready and rready are low there.
- Only one outstanding transaction ever exists.
- The UART write channel and the memory read channel are not driven; the top level ties them idle.

Decomposition:
- Package `loader_types`:
  - loader_state_e enum.
  - RX_VALID_BIT=8.
  - HEADER_BYTES=4.
  - AXI resp constant OKAY=2'b00.
- Optional sub-module `byte_to_word_packer`: lane buffer, strobe accumulation, flush/clear. Everything else stays in one FSM.

Test Plan:
- UART responder returns valid bytes 05 00 00 00 11 22 33 44 55 -> one write to awaddr=LOAD_BASE, wdata=64'h0000_0055_4433_2211, wstrb=8'h1F. Then bytes_loaded=5, done=1, busy=0.
- Length 16 with bytes 00..0F -> writes at LOAD_BASE and LOAD_BASE+8 with wdata 64'h0706050403020100 and 64'h0F0E0D0C0B0A0908, wstrb=FF both.
- Length 0 -> no AW/W activity, done=1.
- Random rdata[8]=0 polls between bytes, plus arready/awready/wready stalls including wready before awready -> identical memory image. Valids never drop before handshake; araddr and awaddr stable while valid.
- Length MAX_BYTES+1 -> error=1 with no writes. Separately, bresp=2'b10 on the first word -> error=1 with bytes_loaded=0.
- Assert rst while awvalid=1 -> all outputs return to reset values asynchronously. A subsequent start reloads correctly.

Source files
------------

// File: rtl/uart_axil_program_loader_pkg.sv
// Shared types and constants for the UART-to-memory program loader.
// Holds the FSM state enum and the fixed protocol constants used by the loader.
package loader_types;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_PROCESS,
        ST_AW_W,
        ST_B,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    localparam int RX_VALID_BIT = 8;
    localparam int HEADER_BYTES = 4;
    localparam logic [1:0] OKAY = 2'b00;

endpackage

// File: rtl/axil_interface_if.sv
// AXI4-lite bundle with initiator-side modports for the read and write channels.
interface axil_interface_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport rd_mst (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport wr_mst (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/uart_axil_program_loader_packer.sv
// Collects bytes into the lanes of a 64-bit word and tracks which lanes hold data.
// Clear has priority so a flush and a fresh start both leave unfilled lanes at zero.
module byte_to_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [2:0]  lane,
    input  logic [7:0]  din,
    output logic [63:0] data,
    output logic [7:0]  strb
);
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_reg;
            logic       strb_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= 8'h00;
                    strb_reg <= 1'b0;
                end else if (clear) begin
                    lane_reg <= 8'h00;
                    strb_reg <= 1'b0;
                end else if (load && (lane == 3'(gi))) begin
                    lane_reg <= din;
                    strb_reg <= 1'b1;
                end
            end

            assign data[gi*8 +: 8] = lane_reg;
            assign strb[gi]        = strb_reg;
        end
    endgenerate
endmodule

// File: rtl/uart_axil_program_loader.sv
// Boot-path AXI4-lite initiator: polls the UART RX register for a length-prefixed
// image and writes it to memory as 64-bit words, one outstanding transaction at a time.
module uart_axil_program_loader
    import loader_types::*;
#(
    parameter logic [63:0] UART_RX_ADDR = 64'h1000_0000,
    parameter logic [63:0] LOAD_BASE    = 64'h0000_0000,
    parameter logic [31:0] MAX_BYTES    = 32'd65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    axil_interface_if.rd_mst uart_rd,
    axil_interface_if.wr_mst mem_wr,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      bytes_loaded
);
    loader_state_e state_reg;
    logic [2:0]    hdr_cnt_reg;
    logic [31:0]   len_reg;
    logic [31:0]   pay_idx_reg;
    logic [7:0]    byte_reg;
    logic [63:0]   word_addr_reg;
    logic          arvalid_reg, rready_reg, awvalid_reg, wvalid_reg, bready_reg;
    logic [63:0]   araddr_reg, awaddr_reg;
    logic          busy_reg, done_reg, error_reg;
    logic [31:0]   bytes_loaded_reg;

    logic          start_ok, pk_clear, pk_load;
    logic [31:0]   len_assembled;
    logic [63:0]   pk_data;
    logic [7:0]    pk_strb;
    logic          unused_rdata;

    assign start_ok = start && (state_reg == ST_IDLE || state_reg == ST_DONE ||
                                state_reg == ST_ERROR);
    assign pk_clear = start_ok ||
                      (state_reg == ST_B && mem_wr.bvalid && mem_wr.bresp == OKAY);
    assign pk_load  = (state_reg == ST_PROCESS) && (hdr_cnt_reg == 3'(HEADER_BYTES));
    // Length arrives little-endian; len_reg is zeroed at start so OR-insertion is safe.
    assign len_assembled = len_reg | (32'(byte_reg) << {hdr_cnt_reg[1:0], 3'b000});
    assign unused_rdata  = ^{uart_rd.rdata[63:RX_VALID_BIT+1]};

    byte_to_word_packer u_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (pk_clear),
        .load  (pk_load),
        .lane  (pay_idx_reg[2:0]),
        .din   (byte_reg),
        .data  (pk_data),
        .strb  (pk_strb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            hdr_cnt_reg      <= 3'd0;
            len_reg          <= 32'd0;
            pay_idx_reg      <= 32'd0;
            byte_reg         <= 8'h00;
            word_addr_reg    <= 64'd0;
            arvalid_reg      <= 1'b0;
            rready_reg       <= 1'b0;
            awvalid_reg      <= 1'b0;
            wvalid_reg       <= 1'b0;
            bready_reg       <= 1'b0;
            araddr_reg       <= 64'd0;
            awaddr_reg       <= 64'd0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
            bytes_loaded_reg <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_ok) begin
                        hdr_cnt_reg      <= 3'd0;
                        len_reg          <= 32'd0;
                        pay_idx_reg      <= 32'd0;
                        word_addr_reg    <= LOAD_BASE;
                        bytes_loaded_reg <= 32'd0;
                        done_reg         <= 1'b0;
                        error_reg        <= 1'b0;
                        busy_reg         <= 1'b1;
                        araddr_reg       <= UART_RX_ADDR;
                        arvalid_reg      <= 1'b1;
                        state_reg        <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (uart_rd.arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= ST_R;
                    end
                end
                ST_R: begin
                    if (uart_rd.rvalid) begin
                        rready_reg <= 1'b0;
                        byte_reg   <= uart_rd.rdata[7:0];
                        if (uart_rd.rresp != OKAY) begin
                            busy_reg  <= 1'b0;
                            error_reg <= 1'b1;
                            state_reg <= ST_ERROR;
                        end else if (!uart_rd.rdata[RX_VALID_BIT]) begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= ST_AR;
                        end else begin
                            state_reg <= ST_PROCESS;
                        end
                    end
                end
                ST_PROCESS: begin
                    if (hdr_cnt_reg != 3'(HEADER_BYTES)) begin
                        len_reg     <= len_assembled;
                        hdr_cnt_reg <= hdr_cnt_reg + 3'd1;
                        if (hdr_cnt_reg == 3'(HEADER_BYTES - 1) && len_assembled == 32'd0) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else if (hdr_cnt_reg == 3'(HEADER_BYTES - 1) &&
                                     len_assembled > MAX_BYTES) begin
                            busy_reg  <= 1'b0;
                            error_reg <= 1'b1;
                            state_reg <= ST_ERROR;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= ST_AR;
                        end
                    end else begin
                        pay_idx_reg <= pay_idx_reg + 32'd1;
                        if (pay_idx_reg[2:0] == 3'd7 || pay_idx_reg + 32'd1 == len_reg) begin
                            awaddr_reg  <= word_addr_reg;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= ST_AW_W;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= ST_AR;
                        end
                    end
                end
                ST_AW_W: begin
                    if (mem_wr.awready) awvalid_reg <= 1'b0;
                    if (mem_wr.wready)  wvalid_reg  <= 1'b0;
                    if ((!awvalid_reg || mem_wr.awready) && (!wvalid_reg || mem_wr.wready)) begin
                        bready_reg <= 1'b1;
                        state_reg  <= ST_B;
                    end
                end
                ST_B: begin
                    if (mem_wr.bvalid) begin
                        bready_reg <= 1'b0;
                        if (mem_wr.bresp != OKAY) begin
                            busy_reg  <= 1'b0;
                            error_reg <= 1'b1;
                            state_reg <= ST_ERROR;
                        end else begin
                            // Every packed byte is now committed, so the payload index is the count.
                            bytes_loaded_reg <= pay_idx_reg;
                            word_addr_reg    <= word_addr_reg + 64'd8;
                            if (pay_idx_reg == len_reg) begin
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                                state_reg <= ST_DONE;
                            end else begin
                                arvalid_reg <= 1'b1;
                                state_reg   <= ST_AR;
                            end
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign uart_rd.arvalid = arvalid_reg;
    assign uart_rd.araddr  = araddr_reg;
    assign uart_rd.rready  = rready_reg;
    assign mem_wr.awvalid  = awvalid_reg;
    assign mem_wr.awaddr   = awaddr_reg;
    assign mem_wr.wvalid   = wvalid_reg;
    assign mem_wr.wdata    = pk_data;
    assign mem_wr.wstrb    = pk_strb;
    assign mem_wr.bready   = bready_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign error           = error_reg;
    assign bytes_loaded    = bytes_loaded_reg;
endmodule
